ws2812_frame_ctrl: RTL and testbench

Double-buffered pixel store and update sequencer that sits between the host register interface and the `ws2812` strip driver. It answers the driver's per-pixel address requests from a front bank. The host writes individual pixels, or bulk-fills a colour, into a back bank. It swaps the banks only at a strip frame boundary, so the LEDs never show a torn frame.

---
 rtl/ws2812_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered pixel store for the ws2812 strip driver. The driver reads the front bank,
// the host and fill engine write the back bank, and banks swap only on a frame boundary.
module ws2812_frame_ctrl #(
  parameter int LED_COUNT = 8,
  parameter bit REVERSE   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [8:0]  drv_address_i,
  output logic [7:0]  drv_r_o,
  output logic [7:0]  drv_g_o,
  output logic [7:0]  drv_b_o,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [8:0]  wr_addr_i,
  input  logic [23:0] wr_rgb_i,
  input  logic        fill_req_i,
  input  logic [23:0] fill_rgb_i,
  input  logic        swap_req_i,
  output logic        swap_ack_o,
  output logic        front_sel_o,
  output logic        busy_o
);

  localparam int              AW       = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [9:0]      COUNT_W  = 10'(LED_COUNT);
  localparam logic [8:0]      FIRST    = REVERSE ? 9'(LED_COUNT - 1) : 9'd0;
  localparam logic [AW-1:0]   LAST_IDX = AW'(LED_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SWAP_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_pend_q, swap_pend_d;
  logic          swap_ack_q, swap_ack_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [23:0]   fill_rgb_q, fill_rgb_d;
  logic [8:0]    prev_addr_q, prev_addr_d;
  logic [23:0]   drv_rgb_q, drv_rgb_d;

  logic [23:0]   bank_q [2][LED_COUNT];

  logic          boundary;
  logic          wr_ready;
  logic          wr_in_range;
  logic          rd_in_range;
  logic          we;
  logic [AW-1:0] waddr;
  logic [23:0]   wdata;

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_pend_d = swap_pend_q;
    swap_ack_d  = 1'b0;
    cnt_d       = cnt_q;
    fill_rgb_d  = fill_rgb_q;
    prev_addr_d = drv_address_i;
    drv_rgb_d   = '0;
    we          = 1'b0;
    waddr       = '0;
    wdata       = '0;

    boundary    = (drv_address_i == FIRST) && (prev_addr_q != FIRST);
    wr_ready    = (state_q == ST_IDLE);
    wr_in_range = {1'b0, wr_addr_i} < COUNT_W;
    rd_in_range = {1'b0, drv_address_i} < COUNT_W;

    case (state_q)
      ST_IDLE: begin
        if (wr_valid_i && wr_in_range) begin
          we    = 1'b1;
          waddr = wr_addr_i[AW-1:0];
          wdata = wr_rgb_i;
        end
        if (fill_req_i) begin
          state_d     = ST_FILL;
          fill_rgb_d  = fill_rgb_i;
          cnt_d       = '0;
          swap_pend_d = swap_req_i;
        end else if (swap_req_i) begin
          state_d = ST_SWAP_WAIT;
        end
      end
      ST_FILL: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = fill_rgb_q;
        cnt_d = cnt_q + AW'(1);
        if (swap_req_i) begin
          swap_pend_d = 1'b1;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = swap_pend_d ? ST_SWAP_WAIT : ST_IDLE;
        end
      end
      ST_SWAP_WAIT: begin
        if (boundary) begin
          front_sel_d = ~front_sel_q;
          swap_ack_d  = 1'b1;
          swap_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reading through front_sel_d makes the boundary read come from the new front bank.
    if (rd_in_range) begin
      drv_rgb_d = bank_q[front_sel_d][drv_address_i[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      cnt_q       <= '0;
      fill_rgb_q  <= '0;
      prev_addr_q <= ~FIRST;
      drv_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
      swap_ack_q  <= swap_ack_d;
      cnt_q       <= cnt_d;
      fill_rgb_q  <= fill_rgb_d;
      prev_addr_q <= prev_addr_d;
      drv_rgb_q   <= drv_rgb_d;
    end
  end

  // Bank storage has no reset; a reset cycle simply suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) begin
      bank_q[~front_sel_q][waddr] <= wdata;
    end
  end

  assign drv_r_o     = drv_rgb_q[23:16];
  assign drv_g_o     = drv_rgb_q[15:8];
  assign drv_b_o     = drv_rgb_q[7:0];
  assign wr_ready_o  = wr_ready;
  assign swap_ack_o  = swap_ack_q;
  assign front_sel_o = front_sel_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: directed sequences, a vector table and a
// randomized run compared against a behavioural model of the two pixel banks.
module tb_ws2812_frame_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_valid, fill_req, swap_req;
  logic [8:0]  drv_addr, wr_addr;
  logic [23:0] wr_rgb, fill_rgb;
  logic [7:0]  r, g, b;
  logic        wr_ready, swap_ack, front_sel, busy;

  logic        r_rst, r_wr_valid, r_fill_req, r_swap_req;
  logic [8:0]  r_addr, r_wr_addr;
  logic [23:0] r_wr_rgb, r_fill_rgb;
  logic [7:0]  r_r, r_g, r_b;
  logic        r_wr_ready, r_swap_ack, r_front_sel, r_busy;

  ws2812_frame_ctrl #(.LED_COUNT(N), .REVERSE(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .drv_address_i(drv_addr),
    .drv_r_o(r), .drv_g_o(g), .drv_b_o(b),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_rgb_i(wr_rgb),
    .fill_req_i(fill_req), .fill_rgb_i(fill_rgb), .swap_req_i(swap_req),
    .swap_ack_o(swap_ack), .front_sel_o(front_sel), .busy_o(busy)
  );

  ws2812_frame_ctrl #(.LED_COUNT(N), .REVERSE(1'b1)) dut_rev (
    .clk_i(clk), .rst_i(r_rst), .drv_address_i(r_addr),
    .drv_r_o(r_r), .drv_g_o(r_g), .drv_b_o(r_b),
    .wr_valid_i(r_wr_valid), .wr_ready_o(r_wr_ready), .wr_addr_i(r_wr_addr), .wr_rgb_i(r_wr_rgb),
    .fill_req_i(r_fill_req), .fill_rgb_i(r_fill_rgb), .swap_req_i(r_swap_req),
    .swap_ack_o(r_swap_ack), .front_sel_o(r_front_sel), .busy_o(r_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pixel contents per bank, plus how much work is still outstanding.
  logic [23:0] m_bank [2][N];
  bit          m_known[2][N];
  bit          m_front, m_swap_pending, m_wait, m_ack, m_rgb_known;
  int          m_fill_left, m_fill_idx, m_prev;
  logic [23:0] m_fill_color, m_rgb;

  bit sweep_en;
  int sweep_pos;

  typedef struct {
    logic [8:0]  addr;
    logic [23:0] exp_rgb;
    logic        exp_ready;
  } read_vec_t;
  read_vec_t vecs[6];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelStep();
    bit boundary, back;
    boundary = (drv_addr == 9'd0) && (m_prev != 0);
    if (rst) begin
      m_front = 0; m_fill_left = 0; m_fill_idx = 0; m_swap_pending = 0; m_wait = 0;
      m_prev = -1; m_rgb = '0; m_rgb_known = 1; m_ack = 0;
      return;
    end
    m_ack = 0;
    back  = !m_front;
    if (m_fill_left == 0 && !m_wait) begin
      if (wr_valid && wr_addr < N) begin
        m_bank[back][int'(wr_addr)]  = wr_rgb;
        m_known[back][int'(wr_addr)] = 1;
      end
      if (fill_req) begin
        m_fill_left = N; m_fill_idx = 0; m_fill_color = fill_rgb; m_swap_pending = swap_req;
      end else if (swap_req) begin
        m_wait = 1;
      end
    end else if (m_fill_left > 0) begin
      m_bank[back][m_fill_idx]  = m_fill_color;
      m_known[back][m_fill_idx] = 1;
      m_fill_idx++;
      m_fill_left--;
      if (swap_req) m_swap_pending = 1;
      if (m_fill_left == 0 && m_swap_pending) begin
        m_wait = 1;
        m_swap_pending = 0;
      end
    end else if (boundary) begin
      m_front = !m_front;
      m_ack   = 1;
      m_wait  = 0;
    end
    if (drv_addr < N) begin
      m_rgb       = m_bank[m_front][int'(drv_addr)];
      m_rgb_known = m_known[m_front][int'(drv_addr)];
    end else begin
      m_rgb       = '0;
      m_rgb_known = 1;
    end
    m_prev = int'(drv_addr);
  endtask

  task automatic applyStimulus();
    if (sweep_en) begin
      drv_addr  = (sweep_pos < N) ? 9'(sweep_pos) : 9'd0;
      sweep_pos = (sweep_pos + 1) % (N + 20);
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    bit m_busy;
    m_busy = (m_fill_left > 0) || m_wait;
    checkVal("wr_ready", 32'(wr_ready), 32'(!m_busy));
    checkVal("busy", 32'(busy), 32'(m_busy));
    checkVal("swap_ack", 32'(swap_ack), 32'(m_ack));
    checkVal("front_sel", 32'(front_sel), 32'(m_front));
    if (m_rgb_known) checkVal("drv_rgb", 32'({r, g, b}), 32'(m_rgb));
  endtask

  task automatic cycle();
    applyStimulus();
    checkOutput();
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 50 && (m_fill_left > 0 || m_wait); i++) cycle();
  endtask

  task automatic waitAck(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (swap_ack) begin
        seen = 1;
        checkVal({name, "_boundary_addr"}, 32'(drv_addr), 32'd0);
        break;
      end
    end
    checkVal({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    vecs[0] = '{9'd0,   24'h102030, 1'b1};
    vecs[1] = '{9'd7,   24'h102030, 1'b1};
    vecs[2] = '{9'd8,   24'h000000, 1'b1};
    vecs[3] = '{9'd3,   24'h102030, 1'b1};
    vecs[4] = '{9'd9,   24'h000000, 1'b1};
    vecs[5] = '{9'd511, 24'h000000, 1'b1};

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) m_known[k][i] = 0;
    m_prev = -1;

    rst = 1; wr_valid = 0; fill_req = 0; swap_req = 0; drv_addr = 9'd3;
    wr_addr = '0; wr_rgb = '0; fill_rgb = '0;
    r_rst = 1; r_wr_valid = 0; r_fill_req = 0; r_swap_req = 0; r_addr = '0;
    r_wr_addr = '0; r_wr_rgb = '0; r_fill_rgb = '0;
    sweep_en = 0; sweep_pos = 0;
    @(negedge clk);

    // Reset defaults
    for (int i = 0; i < 5; i++) cycle();
    checkVal("reset_rgb", 32'({r, g, b}), 32'd0);
    checkVal("reset_ready", 32'(wr_ready), 32'd1);
    checkVal("reset_busy", 32'(busy), 32'd0);
    checkVal("reset_front", 32'(front_sel), 32'd0);
    checkVal("reset_ack", 32'(swap_ack), 32'd0);
    rst = 0; r_rst = 0;
    sweep_en = 1;

    // Fill then swap in the same request cycle
    fill_req = 1; fill_rgb = 24'h102030; swap_req = 1;
    cycle();
    fill_req = 0; swap_req = 0;
    checkVal("fill_busy_rise", 32'(busy), 32'd1);
    waitAck("fill_swap");
    for (int i = 0; i < N + 20; i++) cycle();

    // Direct read vectors against the freshly swapped bank
    sweep_en = 0;
    foreach (vecs[i]) begin
      drv_addr = vecs[i].addr;
      cycle();
      checkVal($sformatf("vec%0d_rgb", i), 32'({r, g, b}), 32'(vecs[i].exp_rgb));
      checkVal($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(vecs[i].exp_ready));
    end
    sweep_en = 1;

    // Pixel writes, including an out-of-range index that must not alias
    fill_req = 1; fill_rgb = 24'h000000;
    cycle();
    fill_req = 0;
    waitIdle();
    wr_valid = 1; wr_addr = 9'd5; wr_rgb = 24'hFF0000;
    checkVal("ready_px5", 32'(wr_ready), 32'd1);
    cycle();
    wr_addr = 9'd9; wr_rgb = 24'h00FF00;
    checkVal("ready_px9", 32'(wr_ready), 32'd1);
    cycle();
    wr_valid = 0;
    swap_req = 1;
    cycle();
    swap_req = 0;
    waitAck("pixel_swap");
    sweep_en = 0;
    drv_addr = 9'd5; cycle(); checkVal("px5_rgb", 32'({r, g, b}), 32'hFF0000);
    drv_addr = 9'd1; cycle(); checkVal("px1_no_alias", 32'({r, g, b}), 32'h0);
    drv_addr = 9'd9; cycle(); checkVal("oor_read9", 32'({r, g, b}), 32'h0);
    sweep_en = 1;

    // Handshake held off for the whole fill
    fill_req = 1; fill_rgb = 24'h0A0B0C;
    cycle();
    fill_req = 0;
    wr_valid = 1; wr_addr = 9'd2; wr_rgb = 24'h123456;
    for (int i = 0; i < N; i++) begin
      checkVal($sformatf("ready_blocked%0d", i), 32'(wr_ready), 32'd0);
      cycle();
    end
    checkVal("ready_after_fill", 32'(wr_ready), 32'd1);
    cycle();
    wr_valid = 0;

    // No tearing: request the swap mid-frame
    for (int i = 0; i < 2 * (N + 20) && sweep_pos != 4; i++) cycle();
    swap_req = 1;
    cycle();
    swap_req = 0;
    cycle();
    checkVal("no_tear_px5", 32'({r, g, b}), 32'hFF0000);
    checkVal("no_tear_front", 32'(front_sel), 32'd0);
    cycle(); cycle();
    waitAck("tear_swap");
    sweep_en = 0;
    drv_addr = 9'd2; cycle(); checkVal("px2_handshake", 32'({r, g, b}), 32'h123456);
    drv_addr = 9'd0; cycle(); checkVal("px0_fill", 32'({r, g, b}), 32'h0A0B0C);
    sweep_en = 1;

    // Reset in the middle of a fill with a swap pending
    fill_req = 1; fill_rgb = 24'h556677; swap_req = 1;
    cycle();
    fill_req = 0; swap_req = 0;
    cycle(); cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    checkVal("midfill_busy", 32'(busy), 32'd0);
    checkVal("midfill_front", 32'(front_sel), 32'd0);
    for (int i = 0; i < 60; i++) begin
      cycle();
      checkVal("midfill_no_ack", 32'(swap_ack), 32'd0);
    end

    // REVERSE=1 instance: only the transition to address 7 is a boundary
    r_fill_req = 1; r_fill_rgb = 24'hC0FFEE; r_swap_req = 1;
    cycle();
    r_fill_req = 0; r_swap_req = 0;
    for (int i = 0; i < N + 4; i++) begin
      cycle();
      checkVal("rev_no_ack_at0", 32'(r_swap_ack), 32'd0);
    end
    checkVal("rev_busy_wait", 32'(r_busy), 32'd1);
    r_addr = 9'd7;
    cycle();
    checkVal("rev_ack", 32'(r_swap_ack), 32'd1);
    checkVal("rev_front", 32'(r_front_sel), 32'd1);
    checkVal("rev_boundary_rgb", 32'({r_r, r_g, r_b}), 32'hC0FFEE);
    r_addr = 9'd3;
    cycle();
    checkVal("rev_ack_pulse", 32'(r_swap_ack), 32'd0);
    checkVal("rev_busy_done", 32'(r_busy), 32'd0);
    checkVal("rev_px3", 32'({r_r, r_g, r_b}), 32'hC0FFEE);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 9'($urandom_range(0, 9));
      wr_rgb   = 24'($urandom);
      fill_rgb = 24'($urandom);
      fill_req = ($urandom_range(0, 39) == 0);
      swap_req = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst = 0; wr_valid = 0; fill_req = 0; swap_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
